cdc_lane_arbiter: RTL and testbench
===================================

Name: cdc_lane_arbiter

Overview:
- Source-domain scheduler that shares one CE-based synchronizer data lane among N_REQ requesters.
- Picks a requester round-robin and drives its data word onto the lane.
- Holds the word stable for a programmable number of cycles, so the destination's stability-detect enable can sample it.
- Then forces an idle gap before the next transfer.
- Single clock; sits directly in front of the lane's destination-side synchronizer.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, 8, lane data width.
- CNT_W, 8, width of the hold/gap length inputs and internal counter.
- HOLD_MIN, 3, minimum hold cycles enforced regardless of hold_len; must be >= 1.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level.
- din  in  N_REQ*DW  packed data; requester i occupies bits [i*DW +: DW].
- hold_len  in  CNT_W  requested hold length in cycles.
- gap_len  in  CNT_W  idle gap length in cycles.
- gnt  out  N_REQ  one-hot, one-cycle accept pulse.
- lane_data  out  DW  data word to the synchronizer lane.
- lane_valid  out  1  high while lane_data is being presented.
- lane_src  out  clog2(N_REQ)  index of the last granted requester.
- busy  out  1  high in HOLD and GAP states.

Behaviour:
- Reset (async assert, synchronous deassert by the integrating design):
  - gnt=0, lane_data=0, lane_valid=0, lane_src=0, busy=0.
  - State=IDLE, counter=0.
  - RR pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, HOLD, GAP.
- IDLE, at edge with req!=0:
  - Winner = first set bit searching from last+1, wrapping mod N_REQ.
  - Register lane_data=din[winner], lane_src=winner, last=winner.
  - eff_hold = max(hold_len, HOLD_MIN); latch eff_hold and gap_len.
  - Load counter=eff_hold; go to HOLD.
  - gnt[winner]=1 for exactly the first HOLD cycle.
- IDLE with req==0: stay; all outputs retain their values, lane_valid=0.
- HOLD:
  - lane_valid=1, busy=1; lane_data frozen.
  - Counter decrements each cycle.
  - When counter==1: if latched gap==0, go to IDLE; else load counter=gap and go to GAP.
- GAP:
  - lane_valid=0, busy=1; lane_data and lane_src retain the transferred word (no toggling on the lane).
  - Counter decrements; at counter==1, go to IDLE.
- Timing, with the grant edge at cycle k:
  - lane_valid high exactly on cycles k+1 .. k+H (H=eff_hold).
  - GAP spans cycles k+H+1 .. k+H+G.
  - Earliest next lane_valid is k+H+G+2.
  - So lane_valid is low for at least G+1 cycles between transfers.
- req is sampled only in IDLE:
  - A requester must deassert req after seeing gnt, or it is re-arbitrated.
  - A req dropped before grant is ignored.
  - din of the winner is sampled only at the grant edge.
- hold_len and gap_len changes during HOLD/GAP have no effect on the transfer in flight.
- Simultaneous requests: exactly one grant per arbitration; gnt is never multi-hot.
- Reset mid-HOLD/GAP: immediate return to reset values. The transfer is aborted with no gnt replay; the pointer resets.
- Counter width: eff_hold and gap use CNT_W bits, with no overflow. hold_len=0 is clamped to HOLD_MIN.

Test Plan:
- Single requester:
  - Stimulus: req=0001, din0=8'hA5, hold_len=5, gap_len=2.
  - Response: gnt=0001 for 1 cycle; lane_valid high for 5 cycles with lane_data=A5; busy for 7 cycles; then IDLE.
- Contention:
  - Stimulus: req=1111 held continuously, din_i=8'h10+i, hold_len=3, gap_len=1.
  - Response: lane_data sequence 10,11,12,13,10; each lane_valid burst is 3 cycles; lane_valid low for 2 cycles between bursts.
- Clamp:
  - Stimulus: hold_len=0, then hold_len=1, HOLD_MIN=3.
  - Response: lane_valid high for exactly 3 cycles in both cases.
- Zero gap:
  - Stimulus: gap_len=0, req=0011 held.
  - Response: lane_valid low for exactly 1 cycle between transfers; GAP state is never entered.
- Reset mid-HOLD:
  - Stimulus: assert rst_n=0 on the 2nd HOLD cycle, release, keep req=0100.
  - Response: all outputs read 0 immediately; after release, requester 2 is granted as a fresh transfer.
- Config change in flight:
  - Stimulus: change hold_len from 4 to 9 during HOLD.
  - Response: current burst stays 4 cycles; the next burst is 9 cycles.

Source files
------------

// File: rtl/cdc_lane_arbiter.sv
// Round-robin scheduler sharing one CE-based synchronizer data lane among N_REQ requesters.
// Latency: grant edge registers the word; lane_valid rises the next cycle for max(hold_len,HOLD_MIN) cycles, then gap_len idle cycles.
// Backpressure: requests are sampled only while idle; an ungranted requester simply waits with req held.
// Ports: clk/rst_n (async active-low); req/din per-requester level and packed data;
//        hold_len/gap_len transfer timing; gnt one-hot accept pulse; lane_data/lane_valid/lane_src lane drive; busy in HOLD/GAP.
module cdc_lane_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int CNT_W    = 8,
  parameter int HOLD_MIN = 3,
  localparam int SW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din,
  input  logic [CNT_W-1:0]    hold_len,
  input  logic [CNT_W-1:0]    gap_len,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       lane_data,
  output logic                lane_valid,
  output logic [SW-1:0]       lane_src,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] gap_q, gap_nxt;
  logic [SW-1:0]    last;
  logic [SW-1:0]    winner;
  logic             win_vld;
  logic             grant;
  logic [CNT_W-1:0] eff_hold;

  // The destination needs several stable cycles to sample, so short holds are stretched.
  assign eff_hold = (hold_len < CNT_W'(HOLD_MIN)) ? CNT_W'(HOLD_MIN) : hold_len;

  // Round-robin pick: scan offsets from far to near so the nearest requester after
  // 'last' overwrites any farther one and wins.
  always_comb begin : rr_pick
    logic [SW-1:0] idx;
    idx     = '0;
    winner  = '0;
    win_vld = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = SW'((int'(last) + off) % N_REQ);
      if (req[idx]) begin
        winner  = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap_q;
    grant     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          grant     = 1'b1;
          state_nxt = S_HOLD;
          cnt_nxt   = eff_hold;
          gap_nxt   = gap_len;
        end
      end
      S_HOLD: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (gap_q == '0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_GAP;
            cnt_nxt   = gap_q;
          end
        end
      end
      S_GAP: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gap_q     <= '0;
      last      <= SW'(N_REQ - 1);
      gnt       <= '0;
      lane_data <= '0;
      lane_src  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      gap_q <= gap_nxt;
      // gnt is high only for the first HOLD cycle.
      gnt   <= grant ? (N_REQ'(1) << winner) : '0;
      // lane_data/lane_src stay frozen through HOLD, GAP and IDLE so the lane never toggles.
      if (grant) begin
        lane_data <= din[winner*DW +: DW];
        lane_src  <= winner;
        last      <= winner;
      end
    end
  end

  assign lane_valid = (state == S_HOLD);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_cdc_lane_arbiter.sv
// Bench for cdc_lane_arbiter: directed test-plan steps followed by a randomized phase,
// each observed cycle checked against a transfer-timeline reference model.
// Model predicts grant edge, valid window, busy window and next-allowed grant edge per transfer.
module tb_cdc_lane_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int HM = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] din = '0;
  logic [CW-1:0] hold_len = '0;
  logic [CW-1:0] gap_len = '0;
  logic [N-1:0]  gnt;
  logic [DW-1:0] lane_data;
  logic          lane_valid;
  logic [SW-1:0] lane_src;
  logic          busy;

  cdc_lane_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(CW), .HOLD_MIN(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .hold_len(hold_len), .gap_len(gap_len),
    .gnt(gnt), .lane_data(lane_data), .lane_valid(lane_valid), .lane_src(lane_src), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: timeline of the most recent transfer, in edge numbers.
  int            edge_n;
  int            next_ok;
  int            gnt_edge;
  int            valid_until;
  int            busy_until;
  int            m_last;
  logic [DW-1:0] m_data;
  int            m_src;

  int n_asserts = 0;
  int n_fail    = 0;
  int vcnt, bcnt;
  bit rec_en = 1'b0;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last      = N - 1;
    m_data      = '0;
    m_src       = 0;
    gnt_edge    = -1000;
    valid_until = -1000;
    busy_until  = -1000;
    next_ok     = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt),        32'd0);
    chk({tag, "_data"},  32'(lane_data),  32'd0);
    chk({tag, "_valid"}, 32'(lane_valid), 32'd0);
    chk({tag, "_src"},   32'(lane_src),   32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  // One clock: predict from the inputs currently applied, clock, then compare.
  task automatic step();
    int e, w, h, g;
    logic [N-1:0] exp_gnt;
    e = edge_n + 1;
    if (e >= next_ok && req != '0) begin
      w = -1;
      for (int off = 1; off <= N; off++) begin
        if (w < 0 && req[(m_last + off) % N]) w = (m_last + off) % N;
      end
      h = (int'(hold_len) < HM) ? HM : int'(hold_len);
      g = int'(gap_len);
      m_data      = din[w*DW +: DW];
      m_src       = w;
      m_last      = w;
      gnt_edge    = e;
      valid_until = e + h - 1;
      busy_until  = e + h + g - 1;
      next_ok     = e + h + g + 1;
    end
    @(posedge clk);
    #1;
    edge_n  = e;
    exp_gnt = (e == gnt_edge) ? N'(1 << m_src) : '0;
    chk("gnt",        32'(gnt),        32'(exp_gnt));
    chk("lane_data",  32'(lane_data),  32'(m_data));
    chk("lane_src",   32'(lane_src),   32'(m_src));
    chk("lane_valid", 32'(lane_valid), 32'(e <= valid_until));
    chk("busy",       32'(busy),       32'(e <= busy_until));
    if (lane_valid) vcnt++;
    if (busy) bcnt++;
    if (rec_en && gnt != '0) q.push_back(lane_data);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] exp_seq [5];
    edge_n = 0;
    model_reset();
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    // Single requester
    din[7:0] = 8'hA5; hold_len = 8'd5; gap_len = 8'd2;
    req = 4'b0001; vcnt = 0; bcnt = 0;
    step();
    req = '0;
    run(9);
    chk("single_valid_len", 32'(vcnt), 32'd5);
    chk("single_busy_len",  32'(bcnt), 32'd7);

    // Contention, all requesters held
    do_reset();
    din = {8'h13, 8'h12, 8'h11, 8'h10}; hold_len = 8'd3; gap_len = 8'd1;
    req = 4'b1111; q.delete(); rec_en = 1'b1;
    run(25);
    rec_en = 1'b0; req = '0;
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    chk("contention_cnt", 32'(q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < q.size()) chk("contention_seq", 32'(q[i]), 32'(exp_seq[i]));
    end

    // Clamp of short holds
    do_reset();
    gap_len = 8'd0;
    for (int k = 0; k < 2; k++) begin
      hold_len = CW'(k); req = 4'b0001; vcnt = 0;
      step();
      req = '0;
      run(5);
      chk("clamp_valid_len", 32'(vcnt), 32'd3);
    end

    // Zero gap: busy equals valid, one idle cycle between bursts
    do_reset();
    hold_len = 8'd3; gap_len = 8'd0; req = 4'b0011; vcnt = 0; bcnt = 0;
    run(12);
    req = '0;
    chk("zgap_valid_cnt", 32'(vcnt), 32'd9);
    chk("zgap_no_gap",    32'(bcnt), 32'(vcnt));
    run(4);

    // Reset on the second HOLD cycle
    do_reset();
    hold_len = 8'd5; gap_len = 8'd1; din = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b0100;
    step();
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midhold_rst");
    #2;
    rst_n = 1'b1;
    step();
    chk("rst_regrant", 32'(gnt), 32'h4);
    req = '0;
    run(8);

    // hold_len change in flight
    do_reset();
    hold_len = 8'd4; gap_len = 8'd1; req = 4'b0001; vcnt = 0;
    step();
    req = '0;
    step();
    hold_len = 8'd9;
    run(4);
    chk("cfg_cur_len", 32'(vcnt), 32'd4);
    vcnt = 0; req = 4'b0001;
    step();
    req = '0;
    run(11);
    chk("cfg_next_len", 32'(vcnt), 32'd9);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      req      = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
      din      = $urandom;
      hold_len = CW'($urandom_range(0, 6));
      gap_len  = CW'($urandom_range(0, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
